// File: rtl/lenet_frame_sequencer_pkg.sv
// Shared definitions for the LeNet frame sequencer: FSM states and default frame geometry.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package lenet_frame_sequencer_pkg;

  localparam int DEF_IMG_W = 28;
  localparam int DEF_IMG_H = 28;
  localparam int CLASS_W   = 4;
  localparam int IN_PIX_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PASS = 2'd1,
    ST_WAIT = 2'd2,
    ST_DROP = 2'd3
  } seq_state_t;

endpackage

// File: rtl/lenet_frame_sequencer_geom_check.sv
// Column/row tracker for a raster pixel stream; flags beats whose line/frame markers disagree with IMG_W x IMG_H.
// Latency: mismatch is combinational on the current beat; counters update on the clock edge.
// Backpressure: none; every beat presented with beat=1 is counted.
module lenet_frame_sequencer_geom_check #(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28
) (
  input  logic clk,
  input  logic srst,
  input  logic beat,
  input  logic start,
  input  logic line_last,
  input  logic frame_last,
  output logic mismatch
);

  localparam int CW = $clog2(IMG_W + 1);
  localparam int RW = $clog2(IMG_H + 1);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  logic [CW-1:0] col_q;
  logic [CW-1:0] col_eff;
  logic [RW-1:0] row_q;
  logic [RW-1:0] row_eff;
  logic          col_end;

  // A start beat is position (0,0) regardless of what the counters hold.
  always_comb begin
    col_eff  = start ? '0 : col_q;
    row_eff  = start ? '0 : row_q;
    col_end  = (col_eff == COL_LAST);
    mismatch = beat && ((line_last && !col_end) ||
                        (!line_last && col_end) ||
                        (frame_last && (!line_last || (row_eff != ROW_LAST))));
  end

  // Advance the raster position; line_last restarts the column on the next row.
  always_ff @(posedge clk) begin
    if (srst) begin
      col_q <= '0;
      row_q <= '0;
    end else if (beat) begin
      if (line_last) begin
        col_q <= '0;
        row_q <= row_eff + 1'b1;
      end else begin
        col_q <= col_eff + 1'b1;
        row_q <= row_eff;
      end
    end
  end

endmodule

// File: rtl/lenet_frame_sequencer.sv
// Admits one whole pixel frame at a time into LeNet, drops frames arriving while busy, latches the class result.
// Latency: every output is registered; out_* follow in_* by exactly one clk cycle.
// Backpressure: none on the input stream; frames that cannot be accepted are dropped whole. Optional watchdog: LENET_TIMEOUT_EN.
module lenet_frame_sequencer
  import lenet_frame_sequencer_pkg::*;
#(
  parameter int PIX_BITS    = 8,
  parameter int IMG_W       = DEF_IMG_W,
  parameter int IMG_H       = DEF_IMG_H,
  parameter int CNT_W       = 16,
  parameter int TIMEOUT_CYC = 200000
) (
  input  logic                clk,
  input  logic                srst,
  input  logic                in_valid,
  input  logic                in_line_last,
  input  logic                in_frame_last,
  input  logic [IN_PIX_W-1:0] in_pixel,
  input  logic                lenet_done,
  input  logic [CLASS_W-1:0]  lenet_class,
  output logic                out_start,
  output logic                out_valid,
  output logic [PIX_BITS-1:0] out_pixel,
  output logic                busy,
  output logic                res_valid,
  output logic [CLASS_W-1:0]  res_class,
  output logic [CNT_W-1:0]    frames_ok,
  output logic [CNT_W-1:0]    frames_drop,
  output logic                err_geom,
  output logic                err_timeout,
  input  logic                err_clr
);

  seq_state_t          state;
  logic                done_seen;
  logic [PIX_BITS-1:0] pix_fmt;
  logic                fwd_beat;
  logic                start_beat;
  logic                geom_mismatch;
  logic                geom_set;
  logic                to_fire;

  // Signed pixel resizing: pass, sign-extend, or keep the MSBs.
  generate
    if (PIX_BITS == IN_PIX_W) begin : g_pix_pass
      assign pix_fmt = in_pixel;
    end else if (PIX_BITS > IN_PIX_W) begin : g_pix_sext
      assign pix_fmt = {{(PIX_BITS - IN_PIX_W){in_pixel[IN_PIX_W-1]}}, in_pixel};
    end else begin : g_pix_msb
      logic [IN_PIX_W-PIX_BITS-1:0] unused_pix_lsb;
      assign pix_fmt        = in_pixel[IN_PIX_W-1 -: PIX_BITS];
      assign unused_pix_lsb = in_pixel[IN_PIX_W-PIX_BITS-1:0];
    end
  endgenerate

  assign start_beat = in_valid && (state == ST_IDLE);
  assign fwd_beat   = in_valid && ((state == ST_IDLE) || (state == ST_PASS));
  // A single-beat frame can never be a legal IMG_W x IMG_H frame.
  assign geom_set   = geom_mismatch || (start_beat && in_frame_last);

  lenet_frame_sequencer_geom_check #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H)
  ) u_geom (
    .clk        (clk),
    .srst       (srst),
    .beat       (fwd_beat),
    .start      (start_beat),
    .line_last  (in_line_last),
    .frame_last (in_frame_last),
    .mismatch   (geom_mismatch)
  );

`ifdef LENET_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0] TO_FIRE = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [TO_W-1:0] TO_SAT  = TO_W'(TIMEOUT_CYC);

  seq_state_t      state_prev;
  logic [TO_W-1:0] to_cnt;
  logic [TO_W-1:0] to_eff;
  logic            to_active;

  // Cycles spent in the current WAIT/DROP visit; a state change restarts the count at zero.
  always_comb begin
    to_active = (state == ST_WAIT) || (state == ST_DROP);
    to_eff    = (state != state_prev) ? '0 : to_cnt;
    to_fire   = to_active && (to_eff == TO_FIRE);
  end

  // Watchdog counter, saturating past the limit so it fires once per visit.
  always_ff @(posedge clk) begin
    if (srst) begin
      state_prev <= ST_IDLE;
      to_cnt     <= '0;
    end else begin
      state_prev <= state;
      if (!to_active)
        to_cnt <= '0;
      else if (to_eff == TO_SAT)
        to_cnt <= to_eff;
      else
        to_cnt <= to_eff + 1'b1;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYC != 0);
  assign to_fire            = 1'b0;
`endif

  // Frame admission FSM with all outputs registered alongside the state.
  always_ff @(posedge clk) begin
    if (srst) begin
      state       <= ST_IDLE;
      done_seen   <= 1'b0;
      out_start   <= 1'b0;
      out_valid   <= 1'b0;
      out_pixel   <= '0;
      busy        <= 1'b0;
      res_valid   <= 1'b0;
      res_class   <= '0;
      frames_ok   <= '0;
      frames_drop <= '0;
      err_geom    <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      out_start <= 1'b0;
      out_valid <= 1'b0;
      res_valid <= 1'b0;
      err_geom  <= (err_geom & ~err_clr) | geom_set;
`ifdef LENET_TIMEOUT_EN
      err_timeout <= (err_timeout & ~err_clr) | to_fire;
`else
      err_timeout <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            out_start <= 1'b1;
            out_valid <= 1'b1;
            out_pixel <= pix_fmt;
            busy      <= 1'b1;
            if (in_frame_last) begin
              frames_ok <= frames_ok + 1'b1;
              state     <= ST_WAIT;
            end else begin
              state <= ST_PASS;
            end
          end
        end
        ST_PASS: begin
          if (in_valid) begin
            out_valid <= 1'b1;
            out_pixel <= pix_fmt;
            if (in_frame_last) begin
              frames_ok <= frames_ok + 1'b1;
              state     <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (lenet_done) begin
            res_class <= lenet_class;
            res_valid <= 1'b1;
          end
          if (in_valid) begin
            frames_drop <= frames_drop + 1'b1;
            if (!in_frame_last) begin
              state     <= ST_DROP;
              done_seen <= lenet_done | to_fire;
            end else if (lenet_done || to_fire) begin
              // One-beat frame already fully discarded: nothing left to drop.
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end else if (lenet_done || to_fire) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        ST_DROP: begin
          if (lenet_done) begin
            res_class <= lenet_class;
            res_valid <= 1'b1;
          end
          if (in_valid && in_frame_last) begin
            done_seen <= 1'b0;
            if (done_seen || lenet_done || to_fire) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end else begin
              state <= ST_WAIT;
            end
          end else if (lenet_done || to_fire) begin
            done_seen <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lenet_frame_sequencer.sv
// Directed bench for lenet_frame_sequencer with a 4x4 frame geometry.
// Latency: checks outputs one cycle after each applied input vector.
// Backpressure: none; stimulus is a free-running beat table plus hand sequences.
module tb_lenet_frame_sequencer;

  logic        clk = 1'b0;
  logic        srst;
  logic        in_valid;
  logic        in_line_last;
  logic        in_frame_last;
  logic [7:0]  in_pixel;
  logic        lenet_done;
  logic [3:0]  lenet_class;
  logic        out_start;
  logic        out_valid;
  logic [7:0]  out_pixel;
  logic        busy;
  logic        res_valid;
  logic [3:0]  res_class;
  logic [15:0] frames_ok;
  logic [15:0] frames_drop;
  logic        err_geom;
  logic        err_timeout;
  logic        err_clr;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  lenet_frame_sequencer #(
    .PIX_BITS    (8),
    .IMG_W       (4),
    .IMG_H       (4),
    .CNT_W       (16),
    .TIMEOUT_CYC (50)
  ) dut (
    .clk           (clk),
    .srst          (srst),
    .in_valid      (in_valid),
    .in_line_last  (in_line_last),
    .in_frame_last (in_frame_last),
    .in_pixel      (in_pixel),
    .lenet_done    (lenet_done),
    .lenet_class   (lenet_class),
    .out_start     (out_start),
    .out_valid     (out_valid),
    .out_pixel     (out_pixel),
    .busy          (busy),
    .res_valid     (res_valid),
    .res_class     (res_class),
    .frames_ok     (frames_ok),
    .frames_drop   (frames_drop),
    .err_geom      (err_geom),
    .err_timeout   (err_timeout),
    .err_clr       (err_clr)
  );

  typedef struct {
    logic        v, ll, fl;
    logic [7:0]  px;
    logic        d;
    logic [3:0]  c;
    logic        clr;
    logic        es, ev;
    logic [7:0]  ep;
    logic        eb, erv;
    logic [3:0]  erc;
    logic [15:0] eok, edrop;
    logic        eg;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic ll, input logic fl, input logic [7:0] px);
    in_valid      = v;
    in_line_last  = ll;
    in_frame_last = fl;
    in_pixel      = px;
  endtask

  task automatic add_row(input logic v, input logic ll, input logic fl, input logic [7:0] px,
                         input logic d, input logic [3:0] c, input logic clr,
                         input logic es, input logic ev, input logic [7:0] ep,
                         input logic eb, input logic erv, input logic [3:0] erc,
                         input logic [15:0] eok, input logic [15:0] edrop, input logic eg);
    vec_t r;
    r.v = v; r.ll = ll; r.fl = fl; r.px = px; r.d = d; r.c = c; r.clr = clr;
    r.es = es; r.ev = ev; r.ep = ep; r.eb = eb; r.erv = erv; r.erc = erc;
    r.eok = eok; r.edrop = edrop; r.eg = eg;
    vq.push_back(r);
  endtask

  // Clean 4x4 frame that is expected to be forwarded beat for beat.
  task automatic add_fwd_frame(input logic [7:0] base, input logic [15:0] ok0,
                               input logic [15:0] drop, input logic [3:0] rc);
    for (int i = 0; i < 16; i++) begin
      logic [7:0] p;
      p = base + 8'(i);
      add_row(1'b1, (i % 4) == 3, i == 15, p, 1'b0, 4'd0, 1'b0,
              i == 0, 1'b1, p, 1'b1, 1'b0, rc, ok0 + 16'(i == 15), drop, 1'b0);
    end
  endtask

  task automatic add_idle(input int n, input logic eb, input logic [3:0] rc,
                          input logic [15:0] ok, input logic [15:0] drop, input logic eg);
    for (int i = 0; i < n; i++)
      add_row(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 4'd0, 1'b0,
              1'b0, 1'b0, 8'h00, eb, 1'b0, rc, ok, drop, eg);
  endtask

  initial begin
    srst = 1'b1; err_clr = 1'b0; lenet_done = 1'b0; lenet_class = 4'd0;
    drive(1'b0, 1'b0, 1'b0, 8'h00);

    // Table: clean frame, done 10 cycles later with class 7.
    add_fwd_frame(8'h00, 16'd0, 16'd0, 4'd0);
    add_idle(9, 1'b1, 4'd0, 16'd1, 16'd0, 1'b0);
    add_row(0,0,0,8'h00, 1,4'd7,0, 0,0,8'h00, 0,1,4'd7, 16'd1,16'd0,0);
    add_idle(1, 1'b0, 4'd7, 16'd1, 16'd0, 1'b0);
    // Negative pixels forwarded, then a frame arriving before done is dropped; done lands mid-frame.
    add_fwd_frame(8'hF0, 16'd1, 16'd0, 4'd7);
    for (int i = 0; i < 16; i++)
      add_row(1'b1, (i % 4) == 3, i == 15, 8'h40 + 8'(i), i == 5, 4'd3, 1'b0,
              1'b0, 1'b0, 8'h00, i != 15, i == 5, (i >= 5) ? 4'd3 : 4'd7,
              16'd2, 16'd1, 1'b0);
    add_fwd_frame(8'h80, 16'd2, 16'd1, 4'd3);
    add_idle(2, 1'b1, 4'd3, 16'd3, 16'd1, 1'b0);
    add_row(0,0,0,8'h00, 1,4'd5,0, 0,0,8'h00, 0,1,4'd5, 16'd3,16'd1,0);
    // Row 1 ends after 3 pixels: sticky geometry error, then cleared.
    begin
      int k;
      k = 0;
      for (int r = 0; r < 4; r++) begin
        int n;
        n = (r == 1) ? 3 : 4;
        for (int c = 0; c < n; c++) begin
          add_row(1'b1, c == n - 1, (r == 3) && (c == n - 1), 8'h20 + 8'(k), 1'b0, 4'd0, 1'b0,
                  k == 0, 1'b1, 8'h20 + 8'(k), 1'b1, 1'b0, 4'd5,
                  16'd3 + 16'((r == 3) && (c == n - 1)), 16'd1,
                  (r > 1) || ((r == 1) && (c == n - 1)));
          k++;
        end
      end
    end
    add_idle(1, 1'b1, 4'd5, 16'd4, 16'd1, 1'b1);
    add_row(0,0,0,8'h00, 1,4'd2,0, 0,0,8'h00, 0,1,4'd2, 16'd4,16'd1,1);
    add_row(0,0,0,8'h00, 0,4'd0,1, 0,0,8'h00, 0,0,4'd2, 16'd4,16'd1,0);
    add_fwd_frame(8'h60, 16'd4, 16'd1, 4'd2);
    // Done and first beat of a new frame in the same WAIT cycle.
    add_row(1,0,0,8'h90, 1,4'd4,0, 0,0,8'h00, 1,1,4'd4, 16'd5,16'd2,0);
    for (int i = 1; i < 16; i++)
      add_row(1'b1, (i % 4) == 3, i == 15, 8'h90 + 8'(i), 1'b0, 4'd0, 1'b0,
              1'b0, 1'b0, 8'h00, i != 15, 1'b0, 4'd4, 16'd5, 16'd2, 1'b0);
    // err_clr together with a new geometry error: the set wins.
    add_row(1,1,0,8'h11, 0,4'd0,1, 1,1,8'h11, 1,0,4'd4, 16'd5,16'd2,1);

    // Reset state.
    tick();
    tick();
    chk("rst_out_start", 0, out_start, 0);
    chk("rst_out_valid", 0, out_valid, 0);
    chk("rst_out_pixel", 0, out_pixel, 0);
    chk("rst_busy", 0, busy, 0);
    chk("rst_res_valid", 0, res_valid, 0);
    chk("rst_res_class", 0, res_class, 0);
    chk("rst_frames_ok", 0, frames_ok, 0);
    chk("rst_frames_drop", 0, frames_drop, 0);
    chk("rst_err_geom", 0, err_geom, 0);
    chk("rst_err_timeout", 0, err_timeout, 0);
    srst = 1'b0;
    tick();

    foreach (vq[i]) begin
      drive(vq[i].v, vq[i].ll, vq[i].fl, vq[i].px);
      lenet_done  = vq[i].d;
      lenet_class = vq[i].c;
      err_clr     = vq[i].clr;
      tick();
      chk("out_start", i, out_start, vq[i].es);
      chk("out_valid", i, out_valid, vq[i].ev);
      if (vq[i].ev) chk("out_pixel", i, out_pixel, vq[i].ep);
      chk("busy", i, busy, vq[i].eb);
      chk("res_valid", i, res_valid, vq[i].erv);
      chk("res_class", i, res_class, vq[i].erc);
      chk("frames_ok", i, frames_ok, vq[i].eok);
      chk("frames_drop", i, frames_drop, vq[i].edrop);
      chk("err_geom", i, err_geom, vq[i].eg);
      chk("err_timeout", i, err_timeout, 0);
    end
    lenet_done = 1'b0; err_clr = 1'b0;

    // srst in the middle of a frame clears everything; next beat starts a frame.
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, 1'b0, 1'b0, 8'(k));
      tick();
      chk("mid_out_valid", k, out_valid, 1);
    end
    drive(1'b1, 1'b0, 1'b0, 8'h06);
    srst = 1'b1;
    tick();
    srst = 1'b0;
    chk("srst_out_valid", 0, out_valid, 0);
    chk("srst_busy", 0, busy, 0);
    chk("srst_frames_ok", 0, frames_ok, 0);
    chk("srst_frames_drop", 0, frames_drop, 0);
    chk("srst_res_class", 0, res_class, 0);
    chk("srst_err_geom", 0, err_geom, 0);
    drive(1'b1, 1'b0, 1'b0, 8'h77);
    tick();
    chk("post_srst_start", 0, out_start, 1);
    chk("post_srst_pixel", 0, out_pixel, 8'h77);
    chk("post_srst_busy", 0, busy, 1);

    // Clean frame followed by a long silence from LeNet.
    srst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    tick();
    srst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, (i % 4) == 3, i == 15, 8'(i));
      tick();
    end
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    chk("wd_frames_ok", 0, frames_ok, 1);
    chk("wd_busy_enter", 0, busy, 1);
`ifdef LENET_TIMEOUT_EN
    repeat (49) tick();
    chk("wd_err_before", 0, err_timeout, 0);
    chk("wd_busy_before", 0, busy, 1);
    tick();
    chk("wd_err_fire", 0, err_timeout, 1);
    chk("wd_busy_after", 0, busy, 0);
    drive(1'b1, 1'b0, 1'b0, 8'h3C);
    tick();
    chk("wd_next_start", 0, out_start, 1);
    chk("wd_next_pixel", 0, out_pixel, 8'h3C);
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("wd_err_clr", 0, err_timeout, 0);
`else
    repeat (60) tick();
    chk("wait_busy_hold", 0, busy, 1);
    chk("wait_err_timeout", 0, err_timeout, 0);
    chk("wait_no_fwd", 0, out_valid, 0);
    lenet_done = 1'b1; lenet_class = 4'd1;
    tick();
    lenet_done = 1'b0;
    chk("wait_res_valid", 0, res_valid, 1);
    chk("wait_res_class", 0, res_class, 1);
    chk("wait_busy_clear", 0, busy, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
